led_matrix_scan_controller: RTL

Column-scan sequencer for the 5-column LED matrix. It steps a column index 0..4, and holds each column on for a programmable dwell time. A blanking gap separates columns to suppress ghosting. Row data comes from a double-buffered frame register that a producer loads through a valid/ready handshake; new frames are committed only at frame boundaries, so the display never tears.

---
 rtl/led_matrix_scan_controller_if.sv | 14 +
 rtl/led_matrix_scan_controller.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan_controller_if.sv
// Frame load channel between a frame producer and the LED matrix scan controller.
//   load_valid : producer has a frame on load_data
//   load_data  : 5 columns of ROWS bits; column c sits at [c*ROWS +: ROWS]
//   load_ready : controller can accept a frame (back buffer free)
interface led_matrix_scan_controller_if #(
  parameter int unsigned ROWS = 7
);
  logic                  load_valid;
  logic [5*ROWS-1:0]     load_data;
  logic                  load_ready;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/led_matrix_scan_controller.sv
// Column-scan sequencer for a 5-column LED matrix with a double-buffered frame.
// Each column is preceded by a dark blanking gap, then driven for DWELL cycles.
// A loaded frame waits in the back buffer and is promoted to the front buffer
// only at a frame boundary (or while idle), so a displayed frame never tears.
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : 1 = scan, 0 = dark/idle
//   load_if     : frame load handshake (slave side)
//   col_en      : one-hot column drive
//   row_data    : row pattern of the driven column
//   col_index   : current column 0..4
//   frame_start : one-cycle pulse on the first DRIVE cycle of column 0
module led_matrix_scan_controller #(
  parameter int unsigned ROWS  = 7,
  parameter int unsigned DWELL = 1000,
  parameter int unsigned BLANK = 50
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  led_matrix_scan_controller_if.slave   load_if,
  output logic [4:0]                    col_en,
  output logic [ROWS-1:0]               row_data,
  output logic [2:0]                    col_index,
  output logic                          frame_start
);

  localparam int unsigned FW      = 5 * ROWS;
  localparam int unsigned MAX_CNT = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned TW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      col_q, col_d;
  logic            frame_end;
  logic [FW-1:0]   front_q, front_d;
  logic [FW-1:0]   back_q, back_d;
  logic            pending_q, pending_d;
  logic            ready_q, ready_d;
  logic [4:0]      col_en_q, col_en_d;
  logic [ROWS-1:0] row_data_q, row_data_d;
  logic            frame_start_q, frame_start_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      col_q         <= '0;
      front_q       <= '0;
      back_q        <= '0;
      pending_q     <= 1'b0;
      ready_q       <= 1'b1;
      col_en_q      <= '0;
      row_data_q    <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      col_q         <= col_d;
      front_q       <= front_d;
      back_q        <= back_d;
      pending_q     <= pending_d;
      ready_q       <= ready_d;
      col_en_q      <= col_en_d;
      row_data_q    <= row_data_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Next-state: sequencing of blank/drive phases and column stepping
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    col_d     = col_q;
    frame_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        col_d   = '0;
        if (enable) begin
          state_d = (BLANK == 0) ? ST_DRIVE : ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (!enable) begin
          state_d = ST_IDLE;
          timer_d = '0;
          col_d   = '0;
        end else if (timer_q == TW'(BLANK - 1)) begin
          state_d = ST_DRIVE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_DRIVE: begin
        if (!enable) begin
          state_d = ST_IDLE;
          timer_d = '0;
          col_d   = '0;
        end else if (timer_q == TW'(DWELL - 1)) begin
          timer_d = '0;
          state_d = (BLANK == 0) ? ST_DRIVE : ST_BLANK;
          if (col_q == 3'd4) begin
            col_d     = '0;
            frame_end = 1'b1;
          end else begin
            col_d = col_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
        col_d   = '0;
      end
    endcase
  end

  // Outputs: frame buffers, handshake and next display values
  always_comb begin
    front_d       = front_q;
    back_d        = back_q;
    pending_d     = pending_q;
    ready_d       = ready_q;
    col_en_d      = '0;
    row_data_d    = '0;
    frame_start_d = 1'b0;

    // Commit; never collides with a transfer since ready is low while pending
    if (pending_q && (frame_end || (state_q == ST_IDLE))) begin
      front_d   = back_q;
      pending_d = 1'b0;
      ready_d   = 1'b1;
    end
    if (load_if.load_valid && ready_q) begin
      back_d    = load_if.load_data;
      pending_d = 1'b1;
      ready_d   = 1'b0;
    end

    // Column and row come from the same next-state so they never disagree
    if (state_d == ST_DRIVE) begin
      col_en_d = 5'(1) << col_d;
      for (int c = 0; c < 5; c++) begin
        if (col_d == 3'(c)) begin
          row_data_d = front_d[c*ROWS +: ROWS];
        end
      end
      frame_start_d = (col_d == 3'd0) && (timer_d == '0);
    end
  end

  assign load_if.load_ready = ready_q;
  assign col_en             = col_en_q;
  assign row_data           = row_data_q;
  assign col_index          = col_q;
  assign frame_start        = frame_start_q;

endmodule
